wb_ext_arbiter: RTL and testbench

Two-master round-robin arbiter for the SERV peripheral (extension) Wishbone bus. Shares the single peripheral bus, which carries the GPIO and debug UART at 0x4000_0000 and up, between the SERV `o_wb_ext_*` port (master 0) and a second host master such as the SPI host bridge (master 1). It holds the grant for exactly one transaction. An optional watchdog terminates transactions that are never acknowledged.

---
 rtl/wb_arb_pkg.sv | 13 +
 rtl/wb_arb_timeout.sv | 37 +++
 rtl/wb_ext_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_ext_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master peripheral Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef logic mst_idx_t;

  localparam logic [31:0] WB_ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_arb_timeout.sv
// Watchdog counter for the peripheral arbiter: counts BUSY cycles without
// ack and flags expiry when the count reaches TIMEOUT_CYCLES.
module wb_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/wb_ext_arbiter.sv
// Round-robin arbiter sharing the SERV peripheral Wishbone bus between two
// masters, one transaction per grant. Define WB_ARB_TIMEOUT_EN for the watchdog.
module wb_ext_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = WB_ARB_ERR_DATA
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  input  logic [3:0]  i_m0_sel,
  input  logic        i_m0_we,
  input  logic        i_m0_stb,
  input  logic        i_m0_cyc,
  output logic [31:0] o_m0_rdt,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  input  logic [3:0]  i_m1_sel,
  input  logic        i_m1_we,
  input  logic        i_m1_stb,
  input  logic        i_m1_cyc,
  output logic [31:0] o_m1_rdt,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_s_adr,
  output logic [31:0] o_s_dat,
  output logic [3:0]  o_s_sel,
  output logic        o_s_we,
  output logic        o_s_stb,
  output logic        o_s_cyc,
  input  logic [31:0] i_s_rdt,
  input  logic        i_s_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  state_e   state_q, state_d;
  mst_idx_t owner_q, owner_d;
  mst_idx_t last_q, last_d;
  logic     timeout_q, timeout_d;

  logic req0, req1, busy, own_stb, own_cyc, ack, term, expired;

  assign req0    = i_m0_stb & i_m0_cyc;
  assign req1    = i_m1_stb & i_m1_cyc;
  assign busy    = (state_q == BUSY);
  assign own_stb = owner_q ? i_m1_stb : i_m0_stb;
  assign own_cyc = owner_q ? i_m1_cyc : i_m0_cyc;

  // A slave ack in the expiry cycle wins over the watchdog; an abort beats both.
  assign ack  = busy & own_cyc & i_s_ack;
  assign term = busy & own_cyc & ~i_s_ack & expired;

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .clear_i  (~busy),
    .enable_i (busy & ~i_s_ack),
    .expired_o(expired)
  );
`else
  // No watchdog: never expires; the term keeps the limit parameter referenced.
  assign expired = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    timeout_d = timeout_q | term;
    if (!busy) begin
      if (req0 | req1) begin
        owner_d = (req0 & req1) ? ~last_q : req1;
        state_d = BUSY;
      end
    end else if (ack | term | ~own_cyc) begin
      last_d  = owner_q;
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_s_adr = busy ? (owner_q ? i_m1_adr : i_m0_adr) : 32'h0;
  assign o_s_dat = busy ? (owner_q ? i_m1_dat : i_m0_dat) : 32'h0;
  assign o_s_sel = busy ? (owner_q ? i_m1_sel : i_m0_sel) : 4'h0;
  assign o_s_we  = busy & (owner_q ? i_m1_we : i_m0_we);
  assign o_s_stb = busy & own_stb & own_cyc & ~term;
  assign o_s_cyc = busy & own_cyc & ~term;

  assign o_m0_ack = (ack | term) & ~owner_q;
  assign o_m1_ack = (ack | term) & owner_q;
  assign o_m0_err = term & ~owner_q;
  assign o_m1_err = term & owner_q;
  assign o_m0_rdt = (term & ~owner_q) ? ERR_DATA : i_s_rdt;
  assign o_m1_rdt = (term & owner_q) ? ERR_DATA : i_s_rdt;

  assign o_grant   = busy ? {owner_q, ~owner_q} : 2'b00;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_wb_ext_arbiter.sv
// Directed and randomized bench for wb_ext_arbiter (watchdog checks follow WB_ARB_TIMEOUT_EN).
module tb_wb_ext_arbiter;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_rdt;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, s_ack;
  logic [31:0] o_m0_rdt, o_m1_rdt, o_s_adr, o_s_dat;
  logic        o_m0_ack, o_m1_ack, o_m0_err, o_m1_err;
  logic [3:0]  o_s_sel;
  logic        o_s_we, o_s_stb, o_s_cyc, o_timeout;
  logic [1:0]  o_grant;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_ext_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we),
    .i_m0_stb(m0_stb), .i_m0_cyc(m0_cyc),
    .o_m0_rdt(o_m0_rdt), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
    .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we),
    .i_m1_stb(m1_stb), .i_m1_cyc(m1_cyc),
    .o_m1_rdt(o_m1_rdt), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
    .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_sel(o_s_sel), .o_s_we(o_s_we),
    .o_s_stb(o_s_stb), .o_s_cyc(o_s_cyc),
    .i_s_rdt(s_rdt), .i_s_ack(s_ack),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_m(input int m, input logic req, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input logic we);
    if (m == 0) begin
      m0_adr = adr; m0_dat = dat; m0_sel = sel; m0_we = we; m0_stb = req; m0_cyc = req;
    end else begin
      m1_adr = adr; m1_dat = dat; m1_sel = sel; m1_we = we; m1_stb = req; m1_cyc = req;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_s_adr"}, o_s_adr, 32'h0);
    chk({tag, "_s_dat"}, {28'h0, o_s_sel} | o_s_dat, 32'h0);
    chk({tag, "_s_stb_cyc_we"}, {29'h0, o_s_stb, o_s_cyc, o_s_we}, 32'h0);
    chk({tag, "_acks_errs"}, {28'h0, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err}, 32'h0);
    chk({tag, "_grant"}, {30'h0, o_grant}, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    drive_m(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    s_ack = 1'b0;
    s_rdt = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Random-phase reference state
  int          exp_owner, last_srv, ack_wait;
  bit          pend [2];
  int          cool [2];
  logic [31:0] r_adr [2];
  logic [31:0] r_dat [2];
  logic [3:0]  r_sel [2];
  logic        r_we  [2];

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    do_reset();
    rst_n = 1'b0;
    tick();
    chk_quiet("reset");
    chk("reset_timeout", {31'h0, o_timeout}, 32'h0);
    rst_n = 1'b1;

    // Single master write, slave ack two cycles after stb
    drive_m(0, 1'b1, 32'h4000_0000, 32'h0000_0055, 4'hF, 1'b1);
    settle();
    chk("single_req_grant", {30'h0, o_grant}, 32'h0);
    chk("single_req_stb", {31'h0, o_s_stb}, 32'h0);
    tick(); settle();
    chk("single_b1_grant", {30'h0, o_grant}, 32'h1);
    chk("single_b1_stb_cyc_we", {29'h0, o_s_stb, o_s_cyc, o_s_we}, 32'h7);
    chk("single_b1_adr", o_s_adr, 32'h4000_0000);
    chk("single_b1_dat", o_s_dat, 32'h0000_0055);
    chk("single_b1_sel", {28'h0, o_s_sel}, 32'hF);
    chk("single_b1_acks", {30'h0, o_m0_ack, o_m1_ack}, 32'h0);
    tick(); settle();
    chk("single_b2_acks", {30'h0, o_m0_ack, o_m1_ack}, 32'h0);
    tick();
    s_ack = 1'b1; s_rdt = 32'hCAFE_0001;
    settle();
    chk("single_ack_acks", {30'h0, o_m0_ack, o_m1_ack}, 32'h2);
    chk("single_ack_grant", {30'h0, o_grant}, 32'h1);
    chk("single_ack_rdt", o_m0_rdt, 32'hCAFE_0001);
    tick();
    s_ack = 1'b0;
    drive_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    settle();
    chk_quiet("single_after");

    // Contention after reset: m0, m1, m0 with one idle cycle between grants
    do_reset();
    drive_m(0, 1'b1, 32'h4000_0010, 32'h1111_0000, 4'h3, 1'b1);
    drive_m(1, 1'b1, 32'h4000_0020, 32'h2222_0000, 4'hC, 1'b0);
    settle();
    chk("cont_idle_grant", {30'h0, o_grant}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      chk($sformatf("cont%0d_grant", k), {30'h0, o_grant}, (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("cont%0d_adr", k), o_s_adr, (k % 2 == 0) ? 32'h4000_0010 : 32'h4000_0020);
      s_ack = 1'b1;
      settle();
      chk($sformatf("cont%0d_acks", k), {30'h0, o_m0_ack, o_m1_ack}, (k % 2 == 0) ? 32'h2 : 32'h1);
      tick();
      s_ack = 1'b0;
      settle();
      chk($sformatf("cont%0d_gap", k), {30'h0, o_grant}, 32'h0);
    end

    // Abort: m1 granted, drops cyc after three BUSY cycles, pending m0 next
    tick(); settle();
    chk("abort_b1_grant", {30'h0, o_grant}, 32'h2);
    tick(); tick(); settle();
    chk("abort_b3_stb", {31'h0, o_s_stb}, 32'h1);
    chk("abort_b3_acks", {30'h0, o_m0_ack, o_m1_ack}, 32'h0);
    tick();
    drive_m(1, 1'b0, 32'h4000_0020, 32'h2222_0000, 4'hC, 1'b0);
    settle();
    chk("abort_drop_stb_cyc", {30'h0, o_s_stb, o_s_cyc}, 32'h0);
    chk("abort_drop_acks", {30'h0, o_m0_ack, o_m1_ack}, 32'h0);
    tick(); settle();
    chk("abort_idle_grant", {30'h0, o_grant}, 32'h0);
    tick(); settle();
    chk("abort_m0_grant", {30'h0, o_grant}, 32'h1);
    s_ack = 1'b1;
    settle();
    chk("abort_m0_ack", {30'h0, o_m0_ack, o_m1_ack}, 32'h2);
    tick();
    s_ack = 1'b0;
    drive_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    // Slave never acks
    drive_m(0, 1'b1, 32'h4000_0100, 32'h0, 4'hF, 1'b0);
    s_rdt = 32'hA5A5_A5A5;
    tick();
    repeat (TO - 1) tick();
    settle();
    chk("to_b16_ack", {30'h0, o_m0_ack, o_m0_err}, 32'h0);
    tick(); settle();
`ifdef WB_ARB_TIMEOUT_EN
    chk("to_b17_ack_err", {30'h0, o_m0_ack, o_m0_err}, 32'h3);
    chk("to_b17_rdt", o_m0_rdt, 32'hDEAD_BEEF);
    chk("to_b17_stb_cyc", {30'h0, o_s_stb, o_s_cyc}, 32'h0);
    chk("to_b17_m1", {30'h0, o_m1_ack, o_m1_err}, 32'h0);
    tick();
    drive_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    settle();
    chk("to_after_flag", {31'h0, o_timeout}, 32'h1);
    chk("to_after_grant", {30'h0, o_grant}, 32'h0);
    tick(); tick(); settle();
    chk("to_sticky", {31'h0, o_timeout}, 32'h1);
`else
    chk("hold_b17_ack_err", {30'h0, o_m0_ack, o_m0_err}, 32'h0);
    chk("hold_b17_grant", {30'h0, o_grant}, 32'h1);
    repeat (23) tick();
    settle();
    chk("hold_b40_stb", {31'h0, o_s_stb}, 32'h1);
    chk("hold_b40_ack", {30'h0, o_m0_ack, o_m0_err}, 32'h0);
    s_ack = 1'b1;
    settle();
    chk("hold_ack", {30'h0, o_m0_ack, o_m0_err}, 32'h2);
    chk("hold_rdt", o_m0_rdt, 32'hA5A5_A5A5);
    tick();
    s_ack = 1'b0;
    drive_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    settle();
    chk("hold_timeout_flag", {31'h0, o_timeout}, 32'h0);
`endif

    // Ack arriving exactly on the expiry cycle
    do_reset();
    drive_m(0, 1'b1, 32'h4000_0200, 32'h0, 4'hF, 1'b0);
    tick();
    repeat (TO) tick();
    s_ack = 1'b1; s_rdt = 32'h1234_5678;
    settle();
    chk("race_ack_err", {30'h0, o_m0_ack, o_m0_err}, 32'h2);
    chk("race_rdt", o_m0_rdt, 32'h1234_5678);
    tick();
    s_ack = 1'b0;
    drive_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    settle();
    chk("race_timeout", {31'h0, o_timeout}, 32'h0);

    // Reset in the middle of a BUSY transaction
    drive_m(1, 1'b1, 32'h4000_0300, 32'h3, 4'h1, 1'b1);
    tick(); settle();
    chk("rst_busy_grant", {30'h0, o_grant}, 32'h2);
    rst_n = 1'b0;
    tick(); settle();
    chk_quiet("rst_mid");
    chk("rst_mid_timeout", {31'h0, o_timeout}, 32'h0);
    rst_n = 1'b1;
    drive_m(0, 1'b1, 32'h4000_0400, 32'h4, 4'h2, 1'b1);
    tick(); settle();
    chk("rst_tie_grant", {30'h0, o_grant}, 32'h1);
    s_ack = 1'b1;
    settle();
    chk("rst_tie_ack", {30'h0, o_m0_ack, o_m1_ack}, 32'h2);
    tick();
    s_ack = 1'b0;

    // Randomized traffic against a transaction-level model
    do_reset();
    exp_owner = -1;
    last_srv = 1;
    ack_wait = 0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0;
      cool[m] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (cool[m] > 0) begin
          cool[m]--;
        end else if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m]  = 1'b1;
          r_adr[m] = 32'h4000_0000 | ($urandom & 32'h0000_FFFC);
          r_dat[m] = $urandom;
          r_sel[m] = 4'($urandom);
          r_we[m]  = 1'($urandom);
        end
        if (pend[m]) drive_m(m, 1'b1, r_adr[m], r_dat[m], r_sel[m], r_we[m]);
        else         drive_m(m, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      end
      s_rdt = $urandom;
      s_ack = (exp_owner >= 0) ? (ack_wait == 0) : 1'($urandom_range(0, 1));
      settle(); settle();
      if (exp_owner < 0) begin
        chk("rnd_idle_grant", {30'h0, o_grant}, 32'h0);
        chk("rnd_idle_stb_acks", {29'h0, o_s_stb, o_m0_ack, o_m1_ack}, 32'h0);
      end else begin
        chk("rnd_grant", {30'h0, o_grant}, 32'(1 << exp_owner));
        chk("rnd_adr", o_s_adr, r_adr[exp_owner]);
        chk("rnd_dat", o_s_dat, r_dat[exp_owner]);
        chk("rnd_sel_we_stb", {27'h0, o_s_sel, o_s_we}, {27'h0, r_sel[exp_owner], r_we[exp_owner]});
        chk("rnd_stb", {31'h0, o_s_stb}, 32'h1);
        chk("rnd_acks", {30'h0, o_m0_ack, o_m1_ack},
            s_ack ? ((exp_owner == 0) ? 32'h2 : 32'h1) : 32'h0);
        chk("rnd_rdt", (exp_owner == 0) ? o_m0_rdt : o_m1_rdt, s_rdt);
      end
      if (exp_owner >= 0) begin
        if (s_ack) begin
          last_srv        = exp_owner;
          pend[exp_owner] = 1'b0;
          cool[exp_owner] = 1;
          exp_owner       = -1;
        end else begin
          ack_wait--;
        end
      end else if (pend[0] || pend[1]) begin
        exp_owner = (pend[0] && pend[1]) ? 1 - last_srv : (pend[0] ? 0 : 1);
        ack_wait  = $urandom_range(0, 5);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
